// File: rtl/pcie_8b10b_pkg.sv
// Shared 8b/10b line-coding types, K28.5 comma constants and helpers.
//   symbol_t     : 10-bit coded symbol, [9]=a ... [4]=i, [3:0]=fghj
//   K28_5_RDN/P  : K28.5 comma for negative / positive running disparity
//   ser_state_e  : serializer FSM states
//   popcount10() : number of ones in a 10-bit symbol
package pcie_8b10b_pkg;

    typedef logic [9:0] symbol_t;

    localparam symbol_t K28_5_RDN = 10'b0011111010;
    localparam symbol_t K28_5_RDP = 10'b1100000101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    function automatic logic [3:0] popcount10(input symbol_t s);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, s[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tx_symbol_fifo.sv
// Small synchronous symbol FIFO, no bypass path (a word pushed at edge T
// shows up on head at T+1 at the earliest).
//   clk, reset : clock, asynchronous active-high reset (flushes contents)
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   full/empty : status from the registered occupancy count
//   head       : oldest entry, valid while !empty
module tx_symbol_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage needs no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_symbol_serializer.sv
// Final TX PHY stage: buffers 10-bit 8b/10b symbols, shifts them out
// a-bit first one bit per clock, tracks running disparity, fills underflow
// with K28.5 commas of the correct disparity and flags disparity violations.
//   clk, reset     : clock, asynchronous active-high reset
//   tx_en          : 1 = transmit; 0 = finish current symbol then idle
//   sym_in/valid   : input symbol handshake, accepted when sym_ready
//   sym_ready      : FIFO has room (low while in reset)
//   ser_out        : serial line, 0 when idle
//   ser_active     : a symbol is being shifted
//   rd_neg         : running disparity after the symbol on the line
//   comma_inserted : one-cycle pulse when a filler comma is loaded
//   disp_err       : sticky disparity violation on a FIFO symbol
module tx_symbol_serializer
    import pcie_8b10b_pkg::*;
#(
    parameter int      FIFO_DEPTH = 2,
    parameter symbol_t COMMA_RDN  = K28_5_RDN,
    parameter symbol_t COMMA_RDP  = K28_5_RDP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [9:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       ser_out,
    output logic       ser_active,
    output logic       rd_neg,
    output logic       comma_inserted,
    output logic       disp_err
);

    ser_state_e state;
    symbol_t    shift_reg;
    symbol_t    fifo_head;
    symbol_t    load_sym;
    logic [3:0] bit_cnt;
    logic [3:0] load_ones;
    logic       fifo_full;
    logic       fifo_empty;
    logic       out_of_reset;
    logic       push;
    logic       pop;
    logic       load;
    logic       rule_bad;

    // out_of_reset keeps sym_ready low until the first edge after release.
    assign sym_ready = out_of_reset & ~fifo_full;
    assign push      = sym_valid & sym_ready;

    // Load from IDLE, or on the last bit of a symbol so symbols abut.
    assign load = tx_en & ((state == ST_IDLE) |
                           ((state == ST_SHIFT) & (bit_cnt == 4'd9)));
    assign pop  = load & ~fifo_empty;

    assign load_sym  = fifo_empty ? (rd_neg ? COMMA_RDN : COMMA_RDP) : fifo_head;
    assign load_ones = popcount10(load_sym);

    // A symbol must be balanced, or unbalanced in the direction that pulls
    // RD back toward the opposite sign.
    assign rule_bad = (load_ones < 4'd4) | (load_ones > 4'd6) |
                      ((load_ones == 4'd6) & ~rd_neg) |
                      ((load_ones == 4'd4) &  rd_neg);

    assign ser_out    = shift_reg[9];
    assign ser_active = (state == ST_SHIFT);

    tx_symbol_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (sym_in),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            rd_neg         <= 1'b1;
            comma_inserted <= 1'b0;
            disp_err       <= 1'b0;
            out_of_reset   <= 1'b0;
        end else begin
            out_of_reset   <= 1'b1;
            comma_inserted <= 1'b0;
            if (load) begin
                state          <= ST_SHIFT;
                shift_reg      <= load_sym;
                bit_cnt        <= '0;
                comma_inserted <= fifo_empty;
                if (load_ones > 4'd5) begin
                    rd_neg <= 1'b0;
                end else if (load_ones < 4'd5) begin
                    rd_neg <= 1'b1;
                end
                if (!fifo_empty && rule_bad) begin
                    disp_err <= 1'b1;
                end
            end else if (state == ST_SHIFT) begin
                if (bit_cnt == 4'd9) begin
                    // Symbol finished with tx_en low: park with the line at 0.
                    state     <= ST_IDLE;
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else begin
                    shift_reg <= {shift_reg[8:0], 1'b0};
                    bit_cnt   <= bit_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_symbol_serializer.sv
module tb_tx_symbol_serializer;

    localparam int DEPTH = 2;
    localparam logic [9:0] K_RDN = 10'b0011111010;
    localparam logic [9:0] K_RDP = 10'b1100000101;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic       ser_out;
    logic       ser_active;
    logic       rd_neg;
    logic       comma_inserted;
    logic       disp_err;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    tx_symbol_serializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_en          (tx_en),
        .sym_in         (sym_in),
        .sym_valid      (sym_valid),
        .sym_ready      (sym_ready),
        .ser_out        (ser_out),
        .ser_active     (ser_active),
        .rd_neg         (rd_neg),
        .comma_inserted (comma_inserted),
        .disp_err       (disp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue for the FIFO, the symbol on the line and the
    // index of the bit currently driven (-1 = idle).
    logic [9:0] m_q[$];
    logic [9:0] m_cur;
    int         m_pos;
    logic       m_rd, m_err, m_alive, m_comma;

    task automatic model_reset();
        m_q.delete();
        m_cur = '0; m_pos = -1; m_rd = 1'b1; m_err = 1'b0;
        m_alive = 1'b0; m_comma = 1'b0;
    endtask

    task automatic model_step();
        bit do_push, do_load;
        logic [9:0] s;
        int n;
        do_push = sym_valid && m_alive && (m_q.size() < DEPTH);
        do_load = tx_en && (m_pos < 0 || m_pos == 9);
        m_comma = 1'b0;
        if (do_load) begin
            if (m_q.size() > 0) begin
                s = m_q.pop_front();
                n = $countones(s);
                if (n < 4 || n > 6 || (n == 6 && !m_rd) || (n == 4 && m_rd)) m_err = 1'b1;
            end else begin
                s = m_rd ? K_RDN : K_RDP;
                m_comma = 1'b1;
            end
            n = $countones(s);
            if (n > 5) m_rd = 1'b0;
            else if (n < 5) m_rd = 1'b1;
            m_cur = s;
            m_pos = 0;
        end else if (m_pos == 9) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            m_pos++;
        end
        if (do_push) m_q.push_back(sym_in);
        m_alive = 1'b1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_ser_out", ser_out, (m_pos >= 0) ? m_cur[9-m_pos] : 1'b0);
            check("mon_ser_active", ser_active, m_pos >= 0);
            check("mon_sym_ready", sym_ready, m_alive && (m_q.size() < DEPTH));
            check("mon_rd_neg", rd_neg, m_rd);
            check("mon_comma", comma_inserted, m_comma);
            check("mon_disp_err", disp_err, m_err);
        end
    end

    // Sample nb line bits, one per cycle, starting with the next edge.
    task automatic grab(input int nb, output logic [31:0] bits, output int commas);
        bits = '0; commas = 0;
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); @(negedge clk);
            bits = {bits[30:0], ser_out};
            commas += int'(comma_inserted);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (ser_active && n < 20) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check(name, ser_active, 1'b0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        tx_en = 1'b0; sym_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [9:0] sym;
        logic       exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t        tbl[6];
    logic [9:0]  pool[6];
    logic [9:0]  dq[4];
    logic [31:0] bits;
    int          commas;
    int          np;
    logic        r;

    initial begin
        tbl[0] = '{10'b1010101010, 1'b1, 1'b0};  // D21.5, balanced
        tbl[1] = '{10'b1001110100, 1'b1, 1'b0};
        tbl[2] = '{10'b0011110101, 1'b0, 1'b0};  // n=6 at RD-: legal
        tbl[3] = '{10'b1111110000, 1'b0, 1'b1};  // n=6 at RD+: violation
        tbl[4] = '{10'b1100000101, 1'b1, 1'b1};  // n=4 at RD+: legal, err sticky
        tbl[5] = '{10'b1010101010, 1'b1, 1'b1};
        pool = '{10'b1010101010, 10'b1001110100, 10'b0011110101,
                 10'b1100001010, 10'b1111110000, 10'b1110001100};
        dq = '{10'b1010101010, 10'b1001110100, 10'b0101010101, 10'b1110001100};

        model_reset();
        reset = 1'b1; tx_en = 1'b0; sym_valid = 1'b0; sym_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ser_out", ser_out, 1'b0);
        check("rst_ser_active", ser_active, 1'b0);
        check("rst_sym_ready", sym_ready, 1'b0);
        check("rst_rd_neg", rd_neg, 1'b1);
        check("rst_comma", comma_inserted, 1'b0);
        check("rst_disp_err", disp_err, 1'b0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Underflow: alternating K28.5.
        tx_en = 1'b1;
        grab(20, bits, commas);
        check("comma_stream", bits, {12'b0, K_RDN, K_RDP});
        check("comma_pulses", commas, 2);
        tx_en = 1'b0;
        wait_idle("idle_after_commas");

        // Table: one symbol at a time, RD and error after each load.
        for (int k = 0; k < 6; k++) begin
            sym_in = tbl[k].sym; sym_valid = 1'b1;
            @(posedge clk); @(negedge clk);
            sym_valid = 1'b0; tx_en = 1'b1;
            @(posedge clk); @(negedge clk);
            tx_en = 1'b0;
            check($sformatf("tbl%0d_rd", k), rd_neg, tbl[k].exp_rd);
            check($sformatf("tbl%0d_err", k), disp_err, tbl[k].exp_err);
            check($sformatf("tbl%0d_comma", k), comma_inserted, 1'b0);
            r = ser_out;
            grab(9, bits, commas);
            check($sformatf("tbl%0d_bits", k), {r, bits[8:0]}, tbl[k].sym);
        end

        // Backpressure with tx_en low, then in-order drain.
        do_reset();
        np = 0; sym_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sym_in = dq[np];
            r = sym_ready;
            @(posedge clk); @(negedge clk);
            if (r) np++;
        end
        check("bp_pushes", np, DEPTH);
        check("bp_ready_low", sym_ready, 1'b0);
        sym_valid = 1'b0; tx_en = 1'b1;
        grab(30, bits, commas);
        check("drain_order", bits, {2'b0, dq[0], dq[1], K_RDN});
        check("drain_commas", commas, 1);
        tx_en = 1'b0;
        wait_idle("idle_after_drain");

        // tx_en drop mid-symbol, then reset mid-symbol with FIFO occupied.
        sym_valid = 1'b1; sym_in = dq[0];
        @(posedge clk); @(negedge clk);
        sym_in = dq[1];
        @(posedge clk); @(negedge clk);
        sym_valid = 1'b0; tx_en = 1'b1;
        bits = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            bits = {bits[30:0], ser_out};
            if (i == 3) tx_en = 1'b0;
        end
        check("no_truncate", bits, {22'b0, dq[0]});
        @(posedge clk); @(negedge clk);
        check("idle_after_drop", ser_active, 1'b0);
        check("idle_line_low", ser_out, 1'b0);
        tx_en = 1'b1; sym_valid = 1'b1; sym_in = dq[2];
        @(posedge clk); @(negedge clk);
        sym_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        check("midrst_ser_out", ser_out, 1'b0);
        check("midrst_active", ser_active, 1'b0);
        check("midrst_rd_neg", rd_neg, 1'b1);
        check("midrst_ready", sym_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        grab(10, bits, commas);
        check("flush_comma_bits", bits, {22'b0, K_RDN});
        check("flush_comma_pulse", commas, 1);

        // n=7 symbol flags an error on its own.
        tx_en = 1'b0;
        wait_idle("idle_before_n7");
        check("err_clear_after_reset", disp_err, 1'b0);
        sym_in = 10'b1111111000; sym_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        sym_valid = 1'b0; tx_en = 1'b1;
        @(posedge clk); @(negedge clk);
        tx_en = 1'b0;
        check("err_n7", disp_err, 1'b1);
        check("rd_n7", rd_neg, 1'b0);
        wait_idle("idle_after_n7");

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int sel;
            tx_en     = ($urandom_range(0, 7) != 0);
            sym_valid = $urandom_range(0, 1);
            sel       = $urandom_range(0, 7);
            sym_in    = (sel < 6) ? pool[sel] : 10'($urandom);
            @(posedge clk); @(negedge clk);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
